// File: rtl/uart_modport.sv
// APB-attached 8N1 UART with small TX/RX FIFOs, programmable baud divisor
// and a single level interrupt.
module uart_modport #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd15
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic [31:0] paddr,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        uart_int,
    output logic        txd,
    input  logic        rxd
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } uart_st_e;

    logic [7:0]  addr;
    logic        wr_en, rd_en;
    logic        sel_data, sel_stat, sel_ctrl, sel_baud;
    logic [4:0]  ctrl;
    logic [15:0] div;
    logic        rx_overrun, frame_err;
    logic        unused_bits;

    assign addr     = paddr[7:0];
    assign wr_en    = psel & penable & pwrite;
    assign rd_en    = psel & penable & ~pwrite;
    assign sel_data = (addr == 8'h00);
    assign sel_stat = (addr == 8'h04);
    assign sel_ctrl = (addr == 8'h08);
    assign sel_baud = (addr == 8'h0C);

    assign unused_bits = ^{paddr[31:8], pwdata[31:16]};

    // ---------------- TX FIFO ----------------
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wp, tx_rp;
    logic [AW:0]   tx_cnt;
    logic          tx_full, tx_empty, tx_push, tx_pop, tx_busy;

    uart_st_e    tx_st, tx_st_n;
    logic [15:0] tx_bc, tx_bc_n;
    logic [2:0]  tx_idx, tx_idx_n;
    logic [7:0]  tx_sh, tx_sh_n;
    logic        tx_bit_done;

    assign tx_full     = (tx_cnt == FULL_CNT);
    assign tx_empty    = (tx_cnt == '0);
    assign tx_busy     = (tx_st != S_IDLE);
    assign tx_bit_done = (tx_bc == div);

    // Popping at the last stop-bit cycle chains frames with no idle gap.
    assign tx_pop  = ctrl[0] & ~tx_empty &
                     ((tx_st == S_IDLE) | ((tx_st == S_STOP) & tx_bit_done));
    assign tx_push = wr_en & sel_data & (~tx_full | tx_pop);

    always_ff @(posedge pclk) begin
        if (tx_push)
            tx_mem[tx_wp] <= pwdata[7:0];
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push)
                tx_wp <= tx_wp + 1'b1;
            if (tx_pop)
                tx_rp <= tx_rp + 1'b1;
            if (tx_push & ~tx_pop)
                tx_cnt <= tx_cnt + 1'b1;
            else if (~tx_push & tx_pop)
                tx_cnt <= tx_cnt - 1'b1;
        end
    end

    // ---------------- TX FSM ----------------
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tx_st  <= S_IDLE;
            tx_bc  <= '0;
            tx_idx <= '0;
            tx_sh  <= '0;
        end else begin
            tx_st  <= tx_st_n;
            tx_bc  <= tx_bc_n;
            tx_idx <= tx_idx_n;
            tx_sh  <= tx_sh_n;
        end
    end

    always_comb begin
        tx_st_n  = tx_st;
        tx_bc_n  = tx_bc;
        tx_idx_n = tx_idx;
        tx_sh_n  = tx_sh;
        unique case (tx_st)
            S_IDLE: begin
                if (tx_pop) begin
                    tx_st_n = S_START;
                    tx_bc_n = '0;
                    tx_sh_n = tx_mem[tx_rp];
                end
            end
            S_START: begin
                if (tx_bit_done) begin
                    tx_st_n  = S_DATA;
                    tx_bc_n  = '0;
                    tx_idx_n = '0;
                end else begin
                    tx_bc_n = tx_bc + 16'd1;
                end
            end
            S_DATA: begin
                if (tx_bit_done) begin
                    tx_bc_n = '0;
                    tx_sh_n = {1'b1, tx_sh[7:1]};
                    if (tx_idx == 3'd7)
                        tx_st_n = S_STOP;
                    else
                        tx_idx_n = tx_idx + 3'd1;
                end else begin
                    tx_bc_n = tx_bc + 16'd1;
                end
            end
            S_STOP: begin
                if (tx_bit_done) begin
                    tx_bc_n = '0;
                    if (tx_pop) begin
                        tx_st_n = S_START;
                        tx_sh_n = tx_mem[tx_rp];
                    end else begin
                        tx_st_n = S_IDLE;
                    end
                end else begin
                    tx_bc_n = tx_bc + 16'd1;
                end
            end
            default: tx_st_n = S_IDLE;
        endcase
    end

    assign txd = (tx_st == S_START) ? 1'b0 :
                 (tx_st == S_DATA)  ? tx_sh[0] : 1'b1;

    // ---------------- RX synchronizer ----------------
    logic rx_s1, rx_s2, rx_prev;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rxd;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wp, rx_rp;
    logic [AW:0]   rx_cnt;
    logic          rx_full, rx_valid, rx_push, rx_pop;
    logic          rx_ok, rx_ferr, rx_ovr_set;
    logic [7:0]    rx_head;

    uart_st_e    rx_st, rx_st_n;
    logic [15:0] rx_bc, rx_bc_n;
    logic [2:0]  rx_idx, rx_idx_n;
    logic [7:0]  rx_sh, rx_sh_n;
    logic [16:0] div_p1;
    logic [15:0] half;
    logic        rx_bit_done;

    assign rx_full     = (rx_cnt == FULL_CNT);
    assign rx_valid    = (rx_cnt != '0);
    assign rx_head     = rx_mem[rx_rp];
    assign rx_pop      = rd_en & sel_data & rx_valid;
    assign rx_push     = rx_ok & (~rx_full | rx_pop);
    assign rx_ovr_set  = rx_ok & rx_full & ~rx_pop;
    assign div_p1      = {1'b0, div} + 17'd1;
    assign half        = div_p1[16:1];
    assign rx_bit_done = (rx_bc == div);

    always_ff @(posedge pclk) begin
        if (rx_push)
            rx_mem[rx_wp] <= rx_sh;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push)
                rx_wp <= rx_wp + 1'b1;
            if (rx_pop)
                rx_rp <= rx_rp + 1'b1;
            if (rx_push & ~rx_pop)
                rx_cnt <= rx_cnt + 1'b1;
            else if (~rx_push & rx_pop)
                rx_cnt <= rx_cnt - 1'b1;
        end
    end

    // ---------------- RX FSM ----------------
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rx_st  <= S_IDLE;
            rx_bc  <= '0;
            rx_idx <= '0;
            rx_sh  <= '0;
        end else begin
            rx_st  <= rx_st_n;
            rx_bc  <= rx_bc_n;
            rx_idx <= rx_idx_n;
            rx_sh  <= rx_sh_n;
        end
    end

    // rx_bc in START counts cycles since the edge-detect cycle, so a
    // half-period of zero confirms the start bit on the edge itself.
    always_comb begin
        rx_st_n  = rx_st;
        rx_bc_n  = rx_bc;
        rx_idx_n = rx_idx;
        rx_sh_n  = rx_sh;
        rx_ok    = 1'b0;
        rx_ferr  = 1'b0;
        unique case (rx_st)
            S_IDLE: begin
                if (ctrl[1] & rx_prev & ~rx_s2) begin
                    if (half == '0) begin
                        rx_st_n  = S_DATA;
                        rx_bc_n  = '0;
                        rx_idx_n = '0;
                    end else begin
                        rx_st_n = S_START;
                        rx_bc_n = 16'd1;
                    end
                end
            end
            S_START: begin
                if (rx_bc == half) begin
                    rx_bc_n  = '0;
                    rx_idx_n = '0;
                    rx_st_n  = rx_s2 ? S_IDLE : S_DATA;
                end else begin
                    rx_bc_n = rx_bc + 16'd1;
                end
            end
            S_DATA: begin
                if (rx_bit_done) begin
                    rx_bc_n = '0;
                    rx_sh_n = {rx_s2, rx_sh[7:1]};
                    if (rx_idx == 3'd7)
                        rx_st_n = S_STOP;
                    else
                        rx_idx_n = rx_idx + 3'd1;
                end else begin
                    rx_bc_n = rx_bc + 16'd1;
                end
            end
            S_STOP: begin
                if (rx_bit_done) begin
                    rx_bc_n = '0;
                    rx_st_n = S_IDLE;
                    rx_ok   = rx_s2;
                    rx_ferr = ~rx_s2;
                end else begin
                    rx_bc_n = rx_bc + 16'd1;
                end
            end
            default: rx_st_n = S_IDLE;
        endcase
    end

    // ---------------- Registers ----------------
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            ctrl       <= '0;
            div        <= DIV_RESET;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            uart_int   <= 1'b0;
        end else begin
            if (wr_en & sel_ctrl)
                ctrl <= pwdata[4:0];
            if (wr_en & sel_baud)
                div <= pwdata[15:0];
            rx_overrun <= (rx_overrun & ~(wr_en & sel_stat & pwdata[5]))
                          | rx_ovr_set;
            frame_err  <= (frame_err & ~(wr_en & sel_stat & pwdata[6]))
                          | rx_ferr;
            uart_int   <= (ctrl[2] & rx_valid)
                          | (ctrl[3] & tx_empty & ~tx_busy)
                          | (ctrl[4] & (rx_overrun | frame_err));
        end
    end

    always_comb begin
        prdata = '0;
        if (psel & ~pwrite) begin
            unique case (1'b1)
                sel_data: prdata = rx_valid ? {24'b0, rx_head} : 32'b0;
                sel_stat: prdata = {25'b0, frame_err, rx_overrun, tx_busy,
                                    rx_full, rx_valid, tx_empty, tx_full};
                sel_ctrl: prdata = {27'b0, ctrl};
                sel_baud: prdata = {16'b0, div};
                default:  prdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_modport.sv
// Directed self-checking bench for uart_modport: register access,
// TX framing, loopback RX, FIFO limits, overrun, frame error, glitch.
module tb_uart_modport;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic [31:0] paddr = '0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        uart_int;
    logic        txd;
    logic        rxd;
    logic        loop = 1'b0;
    logic        rxd_drv = 1'b1;

    int checks = 0;
    int failures = 0;
    logic [31:0] rd;
    logic [9:0]  frame;
    int          n;

    assign rxd = loop ? txd : rxd_drv;

    always #5 pclk = ~pclk;

    uart_modport dut (
        .pclk    (pclk),
        .presetn (presetn),
        .paddr   (paddr),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .uart_int(uart_int),
        .txd     (txd),
        .rxd     (rxd)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int c);
        repeat (c) @(negedge pclk);
    endtask

    task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
        paddr = {24'h0, a};
        pwdata = d;
        pwrite = 1'b1;
        psel = 1'b1;
        penable = 1'b0;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        psel = 1'b0;
        penable = 1'b0;
        pwrite = 1'b0;
    endtask

    task automatic apb_rd(input logic [7:0] a, output logic [31:0] d);
        paddr = {24'h0, a};
        pwrite = 1'b0;
        psel = 1'b1;
        penable = 1'b0;
        @(negedge pclk);
        penable = 1'b1;
        #1 d = prdata;
        @(negedge pclk);
        psel = 1'b0;
        penable = 1'b0;
    endtask

    // Setup-phase only read: no side effects, no clock edge consumed.
    task automatic peek(input logic [7:0] a, output logic [31:0] d);
        paddr = {24'h0, a};
        pwrite = 1'b0;
        psel = 1'b1;
        penable = 1'b0;
        #1 d = prdata;
        psel = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input int bc);
        rxd_drv = 1'b0;
        wait_cyc(bc);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i];
            wait_cyc(bc);
        end
        rxd_drv = stop;
        wait_cyc(bc);
        rxd_drv = 1'b1;
    endtask

    initial begin
        // Reset state
        wait_cyc(2);
        chk("rst_prdata", prdata, 32'h0);
        chk("rst_txd", {31'b0, txd}, 32'h1);
        chk("rst_int", {31'b0, uart_int}, 32'h0);
        presetn = 1'b1;
        wait_cyc(1);
        peek(8'h04, rd); chk("rst_status", rd, 32'h2);
        peek(8'h0C, rd); chk("rst_baud", rd, 32'hF);
        peek(8'h08, rd); chk("rst_ctrl", rd, 32'h0);
        apb_rd(8'h00, rd); chk("empty_data", rd, 32'h0);
        peek(8'h10, rd); chk("unmapped", rd, 32'h0);

        // TX frame 0xA5 at DIV=3
        apb_wr(8'h0C, 32'h3);
        apb_wr(8'h08, 32'h1);
        apb_wr(8'h00, 32'hA5);
        chk("tx_pre_idle", {31'b0, txd}, 32'h1);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 40; i++) begin
            @(negedge pclk);
            chk($sformatf("tx_bit%0d", i / 4), {31'b0, txd},
                {31'b0, frame[i / 4]});
            if (i == 39) begin
                peek(8'h04, rd);
                chk("tx_busy_last", rd, 32'h12);
            end
        end
        @(negedge pclk);
        peek(8'h04, rd); chk("tx_busy_drop", rd, 32'h2);

        // Loopback receive with rx interrupt
        loop = 1'b1;
        apb_wr(8'h08, 32'h7);
        apb_wr(8'h00, 32'h3C);
        n = 0;
        while (!uart_int && n < 200) begin
            @(negedge pclk);
            n++;
        end
        chk("int_rx_rise", {31'b0, uart_int}, 32'h1);
        peek(8'h04, rd); chk("rx_status", rd, 32'h6);
        apb_rd(8'h00, rd); chk("rx_data", rd, 32'h3C);
        chk("int_lag", {31'b0, uart_int}, 32'h1);
        peek(8'h04, rd); chk("rx_drained", rd, 32'h2);
        @(negedge pclk);
        chk("int_rx_fall", {31'b0, uart_int}, 32'h0);

        // TX FIFO full: 5th byte lost, exactly 4 transmitted
        apb_wr(8'h08, 32'h2);
        apb_wr(8'h00, 32'h11);
        apb_wr(8'h00, 32'h22);
        apb_wr(8'h00, 32'h33);
        apb_wr(8'h00, 32'h44);
        apb_wr(8'h00, 32'h55);
        peek(8'h04, rd); chk("tx_full", rd, 32'h1);
        apb_wr(8'h08, 32'h3);
        wait_cyc(250);
        peek(8'h04, rd); chk("four_rx", rd, 32'hE);
        apb_rd(8'h00, rd); chk("fifo_b0", rd, 32'h11);
        apb_rd(8'h00, rd); chk("fifo_b1", rd, 32'h22);
        apb_rd(8'h00, rd); chk("fifo_b2", rd, 32'h33);
        apb_rd(8'h00, rd); chk("fifo_b3", rd, 32'h44);
        peek(8'h04, rd); chk("fifo_done", rd, 32'h2);

        // RX overrun with ie_err
        apb_wr(8'h08, 32'h13);
        apb_wr(8'h00, 32'hA1);
        apb_wr(8'h00, 32'hA2);
        apb_wr(8'h00, 32'hA3);
        apb_wr(8'h00, 32'hA4);
        apb_wr(8'h00, 32'hA5);
        wait_cyc(300);
        peek(8'h04, rd); chk("ovr_status", rd, 32'h2E);
        chk("ovr_int", {31'b0, uart_int}, 32'h1);
        apb_wr(8'h04, 32'h20);
        peek(8'h04, rd); chk("ovr_w1c", rd, 32'hE);
        wait_cyc(2);
        chk("ovr_int_clr", {31'b0, uart_int}, 32'h0);
        apb_rd(8'h00, rd); chk("ovr_b0", rd, 32'hA1);
        apb_rd(8'h00, rd); chk("ovr_b1", rd, 32'hA2);
        apb_rd(8'h00, rd); chk("ovr_b2", rd, 32'hA3);
        apb_rd(8'h00, rd); chk("ovr_b3", rd, 32'hA4);

        // Frame error, then a good hand-driven frame
        loop = 1'b0;
        apb_wr(8'h08, 32'h12);
        send_frame(8'h5A, 1'b0, 4);
        wait_cyc(10);
        peek(8'h04, rd); chk("ferr_status", rd, 32'h42);
        chk("ferr_int", {31'b0, uart_int}, 32'h1);
        apb_wr(8'h04, 32'h40);
        peek(8'h04, rd); chk("ferr_w1c", rd, 32'h2);
        send_frame(8'hC3, 1'b1, 4);
        wait_cyc(10);
        apb_rd(8'h00, rd); chk("manual_rx", rd, 32'hC3);

        // One-cycle glitch at DIV=7
        apb_wr(8'h0C, 32'h7);
        rxd_drv = 1'b0;
        @(negedge pclk);
        rxd_drv = 1'b1;
        wait_cyc(100);
        peek(8'h04, rd); chk("glitch_status", rd, 32'h2);
        chk("glitch_int", {31'b0, uart_int}, 32'h0);

        // DIV=0 loopback
        apb_wr(8'h0C, 32'h0);
        loop = 1'b1;
        apb_wr(8'h08, 32'h3);
        apb_wr(8'h00, 32'h96);
        wait_cyc(40);
        apb_rd(8'h00, rd); chk("div0_rx", rd, 32'h96);

        // Reset mid-frame
        apb_wr(8'h0C, 32'h3);
        apb_wr(8'h00, 32'h00);
        wait_cyc(6);
        chk("mid_frame_low", {31'b0, txd}, 32'h0);
        presetn = 1'b0;
        #1;
        chk("rst_mid_txd", {31'b0, txd}, 32'h1);
        chk("rst_mid_int", {31'b0, uart_int}, 32'h0);
        peek(8'h04, rd); chk("rst_mid_status", rd, 32'h2);
        peek(8'h0C, rd); chk("rst_mid_baud", rd, 32'hF);
        peek(8'h08, rd); chk("rst_mid_ctrl", rd, 32'h0);
        wait_cyc(2);
        presetn = 1'b1;
        wait_cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
